// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------
// bus_pkg: shared constants and types for the CPU bus arbiter.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package bus_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  localparam logic [N_REQ-1:0] GRANT_NONE = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = GRANT_NONE;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------
// rr_pick: combinational round-robin winner search after `last`.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module rr_pick
  import bus_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    win_idx = last;
    cand    = last;
    any     = |req;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = last + IDX_W'(off);
      if (req[cand]) win_idx = cand;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------
// bus_arbiter_rr: four-master round-robin bus arbiter with hold
// timeout and a one-cycle turnaround between owners.  Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_en,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             timeout
);

  localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  arb_state_t       state;
  logic [IDX_W-1:0] last;
  logic [CNT_W-1:0] hold_cnt;

  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             owner_done;
  logic             owner_drop;
  logic             hold_hit;
  logic             release_now;
  logic             timed_out;

  rr_pick u_pick (
    .req     (req),
    .last    (last),
    .win_idx (win_idx),
    .any     (win_any)
  );

  // A dropped request counts as a release, so it also suppresses timeout.
  assign owner_done  = done[grant_idx];
  assign owner_drop  = ~req[grant_idx];
  assign hold_hit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign release_now = owner_done | owner_drop | hold_hit;
  assign timed_out   = hold_hit & ~owner_done & ~owner_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      grant_en  <= 1'b0;
      grant     <= GRANT_NONE;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      last      <= IDX_W'(N_REQ - 1);
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, TURN: begin
          if (win_any) begin
            state     <= BUSY;
            grant_idx <= win_idx;
            last      <= win_idx;
            hold_cnt  <= '0;
            grant_en  <= 1'b1;
            grant     <= idx_to_onehot(win_idx);
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (hold_cnt != CNT_SAT) hold_cnt <= hold_cnt + CNT_W'(1);
          if (release_now) begin
            state    <= TURN;
            grant_en <= 1'b0;
            grant    <= GRANT_NONE;
            busy     <= 1'b0;
            timeout  <= timed_out;
          end
        end
        default: begin
          state    <= IDLE;
          grant_en <= 1'b0;
          grant    <= GRANT_NONE;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
